// File: rtl/ddr_app_pkg.sv
// Shared DDR app-side definitions: FSM encodings, app command codes and
// parameter legality helpers used by the write feeder and the read drainer.
package ddr_app_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } wr_state_e;

   localparam logic [2:0] APP_CMD_WR = 3'b000;
   localparam logic [2:0] APP_CMD_RD = 3'b001;

   // Returns 1 when the burst/FIFO/region parameters form a legal set.
   function automatic bit feeder_params_ok(int bl_w, int burst_beats, int fifo_aw,
                                           int region_beats, int base_addr, int burst_l);
      bit ok;
      ok = 1'b1;
      if (burst_beats < 1 || burst_beats > (1 << (bl_w - 1)) - 1) ok = 1'b0;
      if ((1 << fifo_aw) < burst_beats) ok = 1'b0;
      if (region_beats < burst_beats || (region_beats % burst_beats) != 0) ok = 1'b0;
      if (burst_l < 1 || (base_addr % burst_l) != 0) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/ddr_sfifo.sv
// Synchronous show-ahead FIFO: dout_o always presents the head word, so a pop
// consumes the word visible in the same cycle. Push is ignored when full.
module ddr_sfifo #(
   parameter int DATA_W = 128,
   parameter int AW     = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] din_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] dout_o,
   output logic [AW:0]       cnt_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int DEPTH = 1 << AW;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       cnt_q;
   logic              do_push;
   logic              do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign dout_o  = mem_q[rd_ptr_q];
   assign cnt_o   = cnt_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/ddr_wr_feeder.sv
// Feeds the DDR write-app stage: buffers user words, issues full or flush-driven
// partial bursts and walks a ring of addresses starting at BASE_ADDR.
module ddr_wr_feeder
   import ddr_app_pkg::*;
#(
   parameter int ADDR_W       = 28,
   parameter int DATA_W       = 128,
   parameter int BURST_L      = 8,
   parameter int BL_W         = 8,
   parameter int BURST_BEATS  = 64,
   parameter int FIFO_AW      = 9,
   parameter int BASE_ADDR    = 0,
   parameter int REGION_BEATS = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_vld,
   input  logic [DATA_W-1:0] s_dat,
   output logic              s_rdy,
   input  logic              flush,
   output logic              flush_done,
   output logic              wr_en,
   output logic [BL_W-1:0]   wr_bl,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_dat,
   input  logic              wr_dat_req,
   input  logic              wr_done,
   input  logic              wr_busy,
   output logic [FIFO_AW:0]  fifo_cnt,
   output logic              wrap,
   output logic              err_unf
);

   localparam int OFF_W = $clog2(REGION_BEATS) + 1;

   if (!feeder_params_ok(BL_W, BURST_BEATS, FIFO_AW, REGION_BEATS, BASE_ADDR, BURST_L))
   begin : g_param_chk
      $error("ddr_wr_feeder: illegal parameter set");
   end

   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   wr_state_e         state_q, state_d;
   logic [BL_W-1:0]   bl_q, bl_d;
   logic [BL_W-1:0]   res_q, res_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic              flush_pend_q, flush_pend_d;
   logic              flush_done_q, flush_done_d;
   logic              wrap_q, wrap_d;
   logic              err_unf_q;
   logic [31:0]       cnt32;
   logic [31:0]       n_cand;
   logic [31:0]       rem;
   logic [31:0]       off_sum;

   assign s_rdy = ~rst & ~fifo_full;
   assign push  = s_vld & s_rdy;
   assign pop   = wr_dat_req & ~fifo_empty;

   ddr_sfifo #(
      .DATA_W (DATA_W),
      .AW     (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   (s_dat),
      .pop_i   (pop),
      .dout_o  (wr_dat),
      .cnt_o   (fifo_cnt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign cnt32 = 32'(fifo_cnt);

   always_comb begin
      state_d      = state_q;
      bl_d         = bl_q;
      res_d        = res_q;
      off_d        = off_q;
      flush_pend_d = flush_pend_q | flush;
      flush_done_d = 1'b0;
      wrap_d       = 1'b0;
      // Burst size never runs past the ring end, so the address wrap is exact.
      n_cand       = (cnt32 >= 32'(BURST_BEATS)) ? 32'(BURST_BEATS) : cnt32;
      rem          = 32'(REGION_BEATS) - 32'(off_q);
      if (n_cand > rem) n_cand = rem;
      off_sum      = 32'(off_q) + 32'(res_q);

      case (state_q)
         ST_IDLE: begin
            if (!wr_busy && (cnt32 >= 32'(BURST_BEATS) || (flush_pend_q && cnt32 != 0))) begin
               state_d = ST_REQ;
               bl_d    = BL_W'(n_cand);
               res_d   = BL_W'(n_cand);
            end else if (flush_pend_q && cnt32 == 0) begin
               flush_pend_d = flush;
               flush_done_d = 1'b1;
            end
         end
         ST_REQ: state_d = ST_WAIT;
         ST_WAIT: begin
            if (wr_done) begin
               state_d = ST_IDLE;
               if (off_sum >= 32'(REGION_BEATS)) begin
                  off_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  off_d = OFF_W'(off_sum);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         bl_q         <= '0;
         res_q        <= '0;
         off_q        <= '0;
         flush_pend_q <= 1'b0;
         flush_done_q <= 1'b0;
         wrap_q       <= 1'b0;
         err_unf_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bl_q         <= bl_d;
         res_q        <= res_d;
         off_q        <= off_d;
         flush_pend_q <= flush_pend_d;
         flush_done_q <= flush_done_d;
         wrap_q       <= wrap_d;
         err_unf_q    <= err_unf_q | (wr_dat_req & fifo_empty);
      end
   end

   assign wr_en      = (state_q == ST_REQ);
   assign wr_bl      = bl_q;
   assign wr_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'(off_q) * ADDR_W'(BURST_L);
   assign flush_done = flush_done_q;
   assign wrap       = wrap_q;
   assign err_unf    = err_unf_q;

endmodule

// File: tb/tb_ddr_wr_feeder.sv
// Directed bench for ddr_wr_feeder with a small ring (128 beats) so that wraps,
// partial bursts and the ring-end clamp are reached in few cycles.
module tb_ddr_wr_feeder;

   localparam int ADDR_W  = 28;
   localparam int DATA_W  = 128;
   localparam int BL_W    = 8;
   localparam int FIFO_AW = 9;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              s_vld = 1'b0;
   logic [DATA_W-1:0] s_dat = '0;
   logic              flush = 1'b0;
   logic              wr_dat_req = 1'b0;
   logic              wr_done = 1'b0;
   logic              wr_busy = 1'b1;
   logic              s_rdy;
   logic              flush_done;
   logic              wr_en;
   logic [BL_W-1:0]   wr_bl;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_dat;
   logic [FIFO_AW:0]  fifo_cnt;
   logic              wrap;
   logic              err_unf;

   ddr_wr_feeder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_L(8), .BL_W(BL_W), .BURST_BEATS(64),
      .FIFO_AW(FIFO_AW), .BASE_ADDR(0), .REGION_BEATS(128)
   ) dut (
      .clk(clk), .rst(rst), .s_vld(s_vld), .s_dat(s_dat), .s_rdy(s_rdy),
      .flush(flush), .flush_done(flush_done), .wr_en(wr_en), .wr_bl(wr_bl),
      .wr_addr(wr_addr), .wr_dat(wr_dat), .wr_dat_req(wr_dat_req),
      .wr_done(wr_done), .wr_busy(wr_busy), .fifo_cnt(fifo_cnt),
      .wrap(wrap), .err_unf(err_unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int push_n;
      int do_flush;
      int exp_bl;
      int exp_addr;
      int exp_addr_after;
      int exp_wraps;
      int exp_fdone;
      int exp_cnt;
   } vec_t;

   vec_t              tbl [6];
   int                checks = 0;
   int                errors = 0;
   int                seq = 0;
   logic [DATA_W-1:0] exp_q [$];

   function automatic logic [DATA_W-1:0] word(int s);
      return {32'(s), ~32'(s), 32'(s) ^ 32'hC3C3_3C3C, 32'(s * 7 + 1)};
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_words(int n);
      int acc = 0;
      int tries = 0;
      while (acc < n && tries < n + 100) begin
         @(negedge clk);
         s_vld = 1'b1;
         s_dat = word(seq);
         if (s_rdy) begin
            exp_q.push_back(s_dat);
            seq++;
            acc++;
         end
         tries++;
      end
      @(negedge clk);
      s_vld = 1'b0;
      if (acc != n) chk("push_accept", acc, n);
   endtask

   task automatic pulse_flush();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic wait_req(int exp_bl, int exp_addr, output bit seen);
      int t = 0;
      @(negedge clk);
      wr_busy = 1'b0;
      while (!wr_en && t < 40) begin
         @(negedge clk);
         t++;
      end
      seen = wr_en;
      chk("wr_en_seen", wr_en, 1);
      if (seen) begin
         chk("wr_bl", wr_bl, exp_bl);
         chk("wr_addr", wr_addr, exp_addr);
      end
      wr_busy = 1'b1;
   endtask

   task automatic run_burst(int exp_bl, int exp_addr);
      bit seen;
      logic [DATA_W-1:0] e;
      wait_req(exp_bl, exp_addr, seen);
      if (seen) begin
         @(negedge clk);
         chk("wr_en_one_cycle", wr_en, 0);
         for (int b = 0; b < exp_bl; b++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            chk("wr_dat", wr_dat, e);
            wr_dat_req = 1'b1;
            @(negedge clk);
         end
         wr_dat_req = 1'b0;
         wr_done = 1'b1;
         chk("wr_bl_stable", wr_bl, exp_bl);
         chk("wr_addr_stable", wr_addr, exp_addr);
         @(negedge clk);
         wr_done = 1'b0;
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_s_rdy", s_rdy, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_bl", wr_bl, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_fifo_cnt", fifo_cnt, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_err_unf", err_unf, 0);
      chk("rst_flush_done", flush_done, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wraps, fdones, bad;
      logic [DATA_W-1:0] e;
      bit seen;

      //            push flush bl addr after wraps fd cnt
      tbl[0] = '{64, 0, 64,   0, 512, 0, 0, 0};
      tbl[1] = '{64, 0, 64, 512,   0, 1, 0, 0};
      tbl[2] = '{10, 1, 10,   0,  80, 0, 1, 0};
      tbl[3] = '{64, 0, 64,  80, 592, 0, 0, 0};
      tbl[4] = '{60, 1, 54, 592,   0, 1, 0, 6};
      tbl[5] = '{ 0, 0,  6,   0,  48, 0, 1, 0};

      repeat (3) @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;
      @(negedge clk);
      chk("s_rdy_after_rst", s_rdy, 1);

      for (int v = 0; v < 6; v++) begin
         push_words(tbl[v].push_n);
         if (tbl[v].do_flush != 0) pulse_flush();
         run_burst(tbl[v].exp_bl, tbl[v].exp_addr);
         wraps = 0;
         fdones = 0;
         for (int c = 0; c < 4; c++) begin
            if (wrap) wraps++;
            if (flush_done) fdones++;
            @(negedge clk);
         end
         chk($sformatf("v%0d_wrap", v), wraps, tbl[v].exp_wraps);
         chk($sformatf("v%0d_flush_done", v), fdones, tbl[v].exp_fdone);
         chk($sformatf("v%0d_addr_after", v), wr_addr, tbl[v].exp_addr_after);
         chk($sformatf("v%0d_fifo_cnt", v), fifo_cnt, tbl[v].exp_cnt);
      end

      // Fill with the writer stalled, then overflow attempts and a push+pop cycle.
      for (int i = 0; i < 520; i++) begin
         @(negedge clk);
         s_vld = 1'b1;
         s_dat = word(seq);
         if (s_rdy) begin
            exp_q.push_back(s_dat);
            seq++;
         end
      end
      @(negedge clk);
      s_vld = 1'b0;
      chk("full_cnt", fifo_cnt, 512);
      chk("full_s_rdy", s_rdy, 0);
      e = exp_q.pop_front();
      chk("full_head", wr_dat, e);
      wr_dat_req = 1'b1;
      @(negedge clk);
      chk("pop_from_full_cnt", fifo_cnt, 511);
      e = exp_q.pop_front();
      chk("pushpop_head", wr_dat, e);
      s_vld = 1'b1;
      s_dat = word(seq);
      if (s_rdy) begin
         exp_q.push_back(s_dat);
         seq++;
      end
      @(negedge clk);
      s_vld = 1'b0;
      wr_dat_req = 1'b0;
      chk("pushpop_cnt", fifo_cnt, 511);
      bad = 0;
      for (int i = 0; i < 511; i++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         if (wr_dat !== e) bad++;
         wr_dat_req = 1'b1;
         @(negedge clk);
      end
      wr_dat_req = 1'b0;
      chk("drain_order_bad", bad, 0);
      chk("drain_cnt", fifo_cnt, 0);
      chk("err_unf_clear", err_unf, 0);

      // Underflow request.
      wr_dat_req = 1'b1;
      @(negedge clk);
      wr_dat_req = 1'b0;
      @(negedge clk);
      chk("err_unf_set", err_unf, 1);
      chk("unf_cnt", fifo_cnt, 0);
      repeat (3) @(negedge clk);
      chk("err_unf_sticky", err_unf, 1);

      // Reset in the middle of a burst.
      push_words(64);
      wait_req(64, 48, seen);
      @(negedge clk);
      for (int b = 0; b < 5; b++) begin
         void'(exp_q.pop_front());
         wr_dat_req = 1'b1;
         @(negedge clk);
      end
      wr_dat_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("s_rdy_after_rst2", s_rdy, 1);
      push_words(64);
      run_burst(64, 0);
      repeat (2) @(negedge clk);
      chk("post_rst_addr_after", wr_addr, 512);
      chk("post_rst_cnt", fifo_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
